demod_sample_buffer: RTL

Buffers lock-in demodulator results for software readout. Sits directly downstream of the QPD demodulator: it captures each (x1, x2, i1, i2) sample on the demodulator done strobe and tags it with a 32-bit sequence number. Samples are held in a show-ahead FIFO and drained through a valid/ready port by the register/AXI readout logic. Readout stalls therefore never lose samples silently: drops are counted, and they are visible as gaps in the sequence numbers.

---
 rtl/demod_sample_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/demod_sample_buffer.sv
// Purpose: captures (x1, x2, i1, i2) demodulator samples on tick_i, tags each with a sequence number, and queues them in a show-ahead FIFO.
// Latency: a sample ticked at edge n is visible at the read port during cycle n+1; a pop at edge n exposes the next entry in cycle n+1.
// Backpressure: rd_ready_i stalls the FIFO. When full with no pop, new ticks are dropped and counted; their sequence numbers still advance.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   tick_i, x1_i..i2_i      sample strobe and signed NUM_BITS sample fields
//   clear_i                 synchronous flush of all queued entries
//   rd_ready_i, rd_valid_o  valid/ready read handshake
//   rd_x1_o..rd_i2_o        head entry sample fields, sign-extended to 32 bits (0 when empty)
//   rd_seq_o                sequence number of the head entry (0 when empty)
//   level_o                 number of queued entries, 0..DEPTH
//   overflow_count_o        saturating count of dropped samples
module demod_sample_buffer #(
    parameter int NUM_BITS = 24,
    parameter int DEPTH    = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      tick_i,
    input  logic [NUM_BITS-1:0]       x1_i,
    input  logic [NUM_BITS-1:0]       x2_i,
    input  logic [NUM_BITS-1:0]       i1_i,
    input  logic [NUM_BITS-1:0]       i2_i,
    input  logic                      clear_i,
    input  logic                      rd_ready_i,
    output logic                      rd_valid_o,
    output logic [31:0]               rd_x1_o,
    output logic [31:0]               rd_x2_o,
    output logic [31:0]               rd_i1_o,
    output logic [31:0]               rd_i2_o,
    output logic [31:0]               rd_seq_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [31:0]               overflow_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [31:0]         seq;
        logic [NUM_BITS-1:0] x1;
        logic [NUM_BITS-1:0] x2;
        logic [NUM_BITS-1:0] i1;
        logic [NUM_BITS-1:0] i2;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [31:0]     seq_cnt;
    logic [31:0]     ovf_cnt;

    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    entry_t          head;

    assign full = (level == LW'(DEPTH));
    assign pop  = (level != '0) && rd_ready_i;
    // A full FIFO still accepts a tick when the head leaves in the same cycle.
    assign push = tick_i && !clear_i && (!full || pop);
    assign drop = tick_i && !clear_i && full && !pop;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            seq_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            // Every tick consumes a sequence number, so drops and flushed
            // samples show up as gaps downstream.
            if (tick_i) begin
                seq_cnt <= seq_cnt + 32'd1;
            end
            if (clear_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    level <= level + 1'b1;
                end else if (pop && !push) begin
                    level <= level - 1'b1;
                end
            end
            if (drop && (ovf_cnt != 32'hFFFF_FFFF)) begin
                ovf_cnt <= ovf_cnt + 32'd1;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by level.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            mem[wr_ptr] <= '{seq: seq_cnt, x1: x1_i, x2: x2_i, i1: i1_i, i2: i2_i};
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        rd_valid_o = (level != '0);
        rd_x1_o    = '0;
        rd_x2_o    = '0;
        rd_i1_o    = '0;
        rd_i2_o    = '0;
        rd_seq_o   = '0;
        if (rd_valid_o) begin
            rd_x1_o  = 32'($signed(head.x1));
            rd_x2_o  = 32'($signed(head.x2));
            rd_i1_o  = 32'($signed(head.i1));
            rd_i2_o  = 32'($signed(head.i2));
            rd_seq_o = head.seq;
        end
    end

    assign level_o          = level;
    assign overflow_count_o = ovf_cnt;

endmodule
